// File: rtl/sample_time_trigger.sv
// Sample-accurate command trigger: queues timed commands, arms the oldest and fires it on a matching strobe.
// Optional build macro SAMPLE_TRIG_LATE_DROP_EN: late commands are discarded silently instead of firing.
module sample_time_trigger #(
  parameter int SAMPLE_CLK_WIDTH = 64,
  parameter int PAYLOAD_WIDTH    = 32,
  parameter int FIFO_DEPTH_LOG2  = 2
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic [SAMPLE_CLK_WIDTH-1:0] sample_idx,
  input  logic                        sample_idx_incr,
  input  logic [SAMPLE_CLK_WIDTH-1:0] cmd_time,
  input  logic [PAYLOAD_WIDTH-1:0]    cmd_payload,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        flush,
  output logic                        trig_valid,
  output logic [PAYLOAD_WIDTH-1:0]    trig_payload,
  output logic                        trig_late,
  output logic                        armed,
  output logic [15:0]                 late_count
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_V = DEPTH[FIFO_DEPTH_LOG2:0];

  logic [SAMPLE_CLK_WIDTH-1:0] mem_time    [DEPTH];
  logic [PAYLOAD_WIDTH-1:0]    mem_payload [DEPTH];

  logic [FIFO_DEPTH_LOG2:0]    wr_ptr_reg, rd_ptr_reg, fill;
  logic                        ready_en_reg;
  logic                        armed_reg;
  logic [SAMPLE_CLK_WIDTH-1:0] armed_time_reg;
  logic [PAYLOAD_WIDTH-1:0]    armed_payload_reg;
  logic                        trig_valid_reg;
  logic [PAYLOAD_WIDTH-1:0]    trig_payload_reg;
  logic [15:0]                 late_count_reg;

  logic                        full, empty, push, load;
  logic [SAMPLE_CLK_WIDTH-1:0] diff;
  logic                        compare, on_time, past, fire, late, trig_next;

  assign fill      = wr_ptr_reg - rd_ptr_reg;
  assign full      = (fill == DEPTH_V);
  assign empty     = (fill == '0);
  // Ready only rises on the first edge after reset release.
  assign cmd_ready = ready_en_reg & ~full & ~flush;
  assign push      = cmd_valid & cmd_ready;

  always_comb begin
    diff      = sample_idx - armed_time_reg;
    compare   = sample_idx_incr & armed_reg & ~flush;
    on_time   = (diff == '0);
    // Modular difference: MSB clear and non-zero means the target lies within the past half range.
    past      = ~diff[SAMPLE_CLK_WIDTH-1] & ~on_time;
    fire      = compare & (on_time | past);
    late      = compare & past;
    load      = ~flush & ~empty & (~armed_reg | fire);
`ifdef SAMPLE_TRIG_LATE_DROP_EN
    trig_next = fire & ~late;
`else
    trig_next = fire;
`endif
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_time[wr_ptr_reg[FIFO_DEPTH_LOG2-1:0]]    <= cmd_time;
      mem_payload[wr_ptr_reg[FIFO_DEPTH_LOG2-1:0]] <= cmd_payload;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ready_en_reg      <= 1'b0;
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      armed_reg         <= 1'b0;
      armed_time_reg    <= '0;
      armed_payload_reg <= '0;
      trig_valid_reg    <= 1'b0;
      trig_payload_reg  <= '0;
      late_count_reg    <= '0;
    end else begin
      ready_en_reg   <= 1'b1;
      trig_valid_reg <= trig_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (flush)     rd_ptr_reg <= wr_ptr_reg;
      else if (load) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      // Zero-bubble refill: a firing slot is reloaded on the same edge.
      if (flush) begin
        armed_reg <= 1'b0;
      end else if (load) begin
        armed_reg         <= 1'b1;
        armed_time_reg    <= mem_time[rd_ptr_reg[FIFO_DEPTH_LOG2-1:0]];
        armed_payload_reg <= mem_payload[rd_ptr_reg[FIFO_DEPTH_LOG2-1:0]];
      end else if (fire) begin
        armed_reg <= 1'b0;
      end
      if (trig_next) trig_payload_reg <= armed_payload_reg;
      if (late && late_count_reg != 16'hFFFF) late_count_reg <= late_count_reg + 16'd1;
    end
  end

`ifdef SAMPLE_TRIG_LATE_DROP_EN
  assign trig_late = 1'b0;
`else
  logic trig_late_reg;
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)       trig_late_reg <= 1'b0;
    else if (trig_next) trig_late_reg <= late;
  end
  assign trig_late = trig_late_reg;
`endif

  assign trig_valid   = trig_valid_reg;
  assign trig_payload = trig_payload_reg;
  assign armed        = armed_reg;
  assign late_count   = late_count_reg;

endmodule

// File: tb/tb_sample_time_trigger.sv
// Scoreboard bench for sample_time_trigger: a queue-based reference model predicts triggers, a monitor checks them.
module tb_sample_time_trigger;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [63:0] sample_idx;
  logic        sample_idx_incr;
  logic [63:0] cmd_time;
  logic [31:0] cmd_payload;
  logic        cmd_valid, cmd_ready, flush;
  logic        trig_valid, trig_late, armed;
  logic [31:0] trig_payload;
  logic [15:0] late_count;

  always #5 clk = ~clk;

  sample_time_trigger dut (
    .clk(clk), .aresetn(aresetn), .sample_idx(sample_idx), .sample_idx_incr(sample_idx_incr),
    .cmd_time(cmd_time), .cmd_payload(cmd_payload), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .flush(flush), .trig_valid(trig_valid), .trig_payload(trig_payload), .trig_late(trig_late),
    .armed(armed), .late_count(late_count)
  );

  typedef struct { logic [63:0] t; logic [31:0] p; int acc; } cmd_t;
  typedef struct { logic [31:0] p; logic late; int cyc; } exp_t;

  cmd_t mq[$];   // commands the model holds, oldest first (head = armed once eligible)
  exp_t sb[$];   // expected triggers

  int          n_total = 0, n_pass = 0;
  int          cyc = 0;
  logic        rdy_en;
  logic        accepted = 1'b0;
  logic [15:0] m_late;
  logic        head_armed, exp_ready, is_late;
  int          fifo_n;
  logic [63:0] diff;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge aresetn) rdy_en <= aresetn;

  // Reference model: evaluates what the upcoming edge must do, from the command-level rules.
  always @(negedge clk) begin
    if (!aresetn) begin
      mq.delete();
      sb.delete();
      m_late   = '0;
      accepted = 1'b0;
      chk("rst_trig_valid", trig_valid, 0);
      chk("rst_trig_payload", trig_payload, 0);
      chk("rst_trig_late", trig_late, 0);
      chk("rst_armed", armed, 0);
      chk("rst_late_count", late_count, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
    end else begin
      head_armed = (mq.size() > 0) && (mq[0].acc + 2 <= cyc);
      fifo_n     = mq.size() - (head_armed ? 1 : 0);
      exp_ready  = rdy_en && (fifo_n < DEPTH) && !flush;
      chk("cmd_ready", cmd_ready, exp_ready);
      chk("armed", armed, head_armed);
      chk("late_count", late_count, m_late);
      accepted = 1'b0;
      if (flush) begin
        mq.delete();
      end else begin
        if (sample_idx_incr && head_armed) begin
          diff = sample_idx - mq[0].t;
          if (diff == 64'd0 || diff < 64'h8000_0000_0000_0000) begin
            is_late = (diff != 64'd0);
            if (is_late && m_late != 16'hFFFF) m_late = m_late + 16'd1;
`ifdef SAMPLE_TRIG_LATE_DROP_EN
            if (!is_late) sb.push_back('{p: mq[0].p, late: 1'b0, cyc: cyc});
`else
            sb.push_back('{p: mq[0].p, late: is_late, cyc: cyc});
`endif
            void'(mq.pop_front());
          end
        end
        if (cmd_valid && exp_ready) begin
          mq.push_back('{t: cmd_time, p: cmd_payload, acc: cyc});
          accepted = 1'b1;
        end
      end
    end
  end

  // Monitor: every trigger the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (aresetn) begin
      if (trig_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_trig", trig_valid, 0);
        end else begin
          e = sb.pop_front();
          $display("trig cyc=%0d payload=%08h late=%0b", cyc, trig_payload, trig_late);
          chk("trig_cycle", cyc, e.cyc + 1);
          chk("trig_payload", trig_payload, e.p);
          chk("trig_late", trig_late, e.late);
        end
      end else begin
        while (sb.size() > 0 && sb[0].cyc + 1 < cyc) begin
          chk("missing_trig", trig_valid, 1);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    sample_idx_incr = 1'b0;
    repeat (n) tick();
  endtask

  task automatic strobe_run(input logic [63:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      sample_idx      = start + 64'(i);
      sample_idx_incr = 1'b1;
      tick();
    end
    sample_idx_incr = 1'b0;
  endtask

  task automatic push(input logic [63:0] t, input logic [31:0] p);
    logic got;
    got         = 1'b0;
    cmd_time    = t;
    cmd_payload = p;
    cmd_valid   = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      tick();
      got = accepted;
    end
    cmd_valid = 1'b0;
    chk("push_accepted", got, 1);
  endtask

  initial begin
    logic [63:0] idx;
    aresetn = 1'b0; sample_idx = '0; sample_idx_incr = 1'b0;
    cmd_time = '0; cmd_payload = '0; cmd_valid = 1'b0; flush = 1'b0;
    repeat (3) tick();
    #2 aresetn = 1'b1;
    idle(2);

    // On-time fire
    push(64'd100, 32'h0000_A5A5);
    idle(2);
    strobe_run(64'd95, 11);
    idle(3);

    // Late command
    strobe_run(64'd500, 1);
    push(64'd400, $urandom);
    idle(2);
    strobe_run(64'd501, 1);
    idle(3);

    // Back-to-back consecutive targets; queue fills to 4 + armed
    for (int i = 0; i < 5; i++) push(64'd10 + 64'(i), $urandom);
    cmd_time = 64'd15; cmd_payload = $urandom; cmd_valid = 1'b1;
    idle(3);
    cmd_valid = 1'b0;
    strobe_run(64'd0, 20);
    idle(3);

    // Wrap-around
    push(64'd1, $urandom);
    idle(2);
    strobe_run(64'hFFFF_FFFF_FFFF_FFFE, 5);
    idle(3);

    // Flush with push attempt on the flush cycle
    for (int i = 0; i < 3; i++) push(64'd50 + 64'(i), $urandom);
    idle(2);
    flush = 1'b1; cmd_valid = 1'b1; cmd_time = 64'd55; cmd_payload = $urandom;
    tick();
    flush = 1'b0; cmd_valid = 1'b0;
    strobe_run(64'd45, 16);
    idle(2);

    // Asynchronous reset while armed
    push(64'd300, $urandom);
    idle(3);
    @(posedge clk); #2 aresetn = 1'b0;
    repeat (3) tick();
    #2 aresetn = 1'b1;
    idle(2);
    strobe_run(64'd295, 11);
    idle(2);

    // Randomized traffic
    idx = 64'd1000;
    for (int i = 0; i < 800; i++) begin
      sample_idx      = idx;
      sample_idx_incr = ($urandom_range(0, 3) != 0);
      cmd_valid       = ($urandom_range(0, 2) == 0);
      cmd_time        = idx + 64'($urandom_range(0, 30)) - 64'd6;
      cmd_payload     = $urandom;
      flush           = ($urandom_range(0, 63) == 0);
      tick();
      if (sample_idx_incr) idx = idx + 64'd1;
    end
    cmd_valid = 1'b0; flush = 1'b0;
    strobe_run(idx, 40);
    idle(5);

    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
